// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address+rw, one data byte (write or read), STOP.
// Every bus phase is split into four quarter-SCL slots timed by a per-transaction divisor.
module i2c_master_ctrl #(
   parameter int unsigned DEFAULT_DIV = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [6:0]  addr,
   input  logic        rw,
   input  logic [7:0]  wdata,
   input  logic [15:0] clk_div,
   output logic        busy,
   output logic        done,
   output logic        ack_err,
   output logic [7:0]  rdata,
   output logic        scl,
   inout  wire         sda
);

   typedef enum logic [2:0] {IDLE, START, ADDR, ACK1, DATA, ACK2, STOP} state_t;

   state_t      state, nxt_state;
   logic [15:0] div, qcnt;
   logic [1:0]  q, nxt_q;
   logic [2:0]  bitn, nxt_bit;
   logic [7:0]  tx_addr, tx_data, shift;
   logic        rw_lat, ack_smp, sda_low, nxt_bitv, tick, sda_in;

   assign sda    = sda_low ? 1'b0 : 1'bz;
   assign sda_in = sda;
   assign tick   = (state != IDLE) && (qcnt == div - 16'd1);

   // Returns {scl, sda_low} for a given phase, quarter and outgoing bit.
   function automatic logic [1:0] bus_drive(input state_t st, input logic [1:0] qq, input logic bitv);
      case (st)
         IDLE:        bus_drive = {1'b1, 1'b0};
         START:       bus_drive = {1'b1, qq[1]};
         ADDR, DATA:  bus_drive = {qq[1], ~bitv};
         ACK1, ACK2:  bus_drive = {qq[1], 1'b0};
         STOP:        bus_drive = (qq == 2'd0) ? {1'b0, 1'b1} :
                                  (qq == 2'd1) ? {1'b1, 1'b1} : {1'b1, 1'b0};
         default:     bus_drive = {1'b1, 1'b0};
      endcase
   endfunction

   // Next phase position, advanced only on quarter ticks.
   always_comb begin
      nxt_state = state;
      nxt_bit   = bitn;
      if (tick) begin
         nxt_q = q + 2'd1;
         if (q == 2'd3) begin
            case (state)
               START: begin nxt_state = ADDR; nxt_bit = 3'd7; end
               ADDR:  if (bitn == 3'd0) nxt_state = ACK1; else nxt_bit = bitn - 3'd1;
               ACK1:  if (ack_smp) nxt_state = STOP; else begin nxt_state = DATA; nxt_bit = 3'd7; end
               DATA:  if (bitn == 3'd0) nxt_state = ACK2; else nxt_bit = bitn - 3'd1;
               ACK2:  nxt_state = STOP;
               STOP:  nxt_state = IDLE;
               default: nxt_state = IDLE;
            endcase
         end else begin
            nxt_state = state;
         end
      end else begin
         nxt_q = q;
      end
      if (nxt_state == ADDR) nxt_bitv = tx_addr[nxt_bit];
      else if (nxt_state == DATA && !rw_lat) nxt_bitv = tx_data[nxt_bit];
      else nxt_bitv = 1'b1;
   end

   // Transaction sequencer with registered bus and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         div     <= 16'd0;
         qcnt    <= 16'd0;
         q       <= 2'd0;
         bitn    <= 3'd0;
         tx_addr <= 8'd0;
         tx_data <= 8'd0;
         shift   <= 8'd0;
         rw_lat  <= 1'b0;
         ack_smp <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         ack_err <= 1'b0;
         rdata   <= 8'd0;
         scl     <= 1'b1;
         sda_low <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            scl     <= 1'b1;
            sda_low <= 1'b0;
            // A start seen in the done cycle is deliberately not accepted.
            if (start && !done) begin
               state   <= START;
               div     <= (clk_div == 16'd0) ? 16'(DEFAULT_DIV) : clk_div;
               qcnt    <= 16'd0;
               q       <= 2'd0;
               bitn    <= 3'd0;
               tx_addr <= {addr, rw};
               tx_data <= wdata;
               rw_lat  <= rw;
               busy    <= 1'b1;
               ack_err <= 1'b0;
            end else begin
               qcnt <= 16'd0;
            end
         end else begin
            qcnt  <= tick ? 16'd0 : qcnt + 16'd1;
            state <= nxt_state;
            q     <= nxt_q;
            bitn  <= nxt_bit;
            {scl, sda_low} <= bus_drive(nxt_state, nxt_q, nxt_bitv);
            // Last clock of Q2 is the sampling point for the slave-driven bits.
            if (tick && q == 2'd2) begin
               case (state)
                  ACK1: begin
                     ack_smp <= sda_in;
                     if (sda_in) ack_err <= 1'b1;
                  end
                  DATA: if (rw_lat) shift <= {shift[6:0], sda_in};
                  ACK2: if (!rw_lat && sda_in) ack_err <= 1'b1;
                  default: ack_smp <= ack_smp;
               endcase
            end
            if (tick && q == 2'd3 && state == ACK2 && rw_lat) rdata <= shift;
            if (tick && q == 2'd3 && state == STOP) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/i2c_master_ctrl.md
I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 Parameter DEFAULT_DIV, default 16: quarter-SCL-period divisor used when clk_div is 0.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  transaction request; sampled only in IDLE.
REQ-005 addr  input  7  target slave address; latched with start.
REQ-006 rw  input  1  0 = write one byte, 1 = read one byte; latched with start.
REQ-007 wdata  input  8  write byte; latched with start.
REQ-008 clk_div  input  16  clk cycles per quarter SCL period; latched with start.
REQ-009 busy  output  1  high from the cycle after start is accepted until done.
REQ-010 done  output  1  one-cycle pulse at transaction end.
REQ-011 ack_err  output  1  set when an expected ACK samples high; valid with done; held until next start.
REQ-012 rdata  output  8  last byte read; updated only on a read with address ACK.
REQ-013 scl  output  1  push-pull SCL, idle high.
REQ-014 sda  inout  1  open-drain: drives 0 or releases (z); the bench provides a pull-up.

Function
REQ-015 States: IDLE, START, ADDR, ACK1, DATA, ACK2, STOP; the state advances only on quarter ticks.
REQ-016 Quarter tick: counter runs 0..D-1 with D = latched clk_div (DEFAULT_DIV if 0); a tick occurs at D-1, then the counter wraps to 0.
REQ-017 Each state lasts 4 quarters Q0..Q3, except ADDR and DATA, which last 8 bits of 4 quarters each.
REQ-018 Bit slot: SCL low in Q0-Q1 and high in Q2-Q3; SDA changes only at Q0 entry; SDA is sampled on the last clk of Q2.
REQ-019 IDLE: scl=1, sda released, busy=0; start=1 latches inputs, clears ack_err and goes to START.
REQ-020 START: Q0-Q1 SCL=1 and SDA released; Q2-Q3 SCL=1 and SDA=0, forming the START condition.
REQ-021 ADDR: shifts {addr, rw} MSB first; bit 1 releases SDA, bit 0 drives it low.
REQ-022 ACK1: SDA released; sample 0 -> DATA; sample 1 -> ack_err=1 -> STOP (DATA and ACK2 skipped).
REQ-023 DATA, write: shifts wdata MSB first. DATA, read: SDA released; 8 samples shifted MSB first into a holding register.
REQ-024 ACK2: SDA released. Write: sample 1 sets ack_err. Read: the sample is ignored and the holding register is copied to rdata at the end of ACK2.
REQ-025 STOP: Q0 SCL=0 SDA=0; Q1 SCL=1 SDA=0; Q2-Q3 SCL=1 and SDA released, forming the STOP condition. At the end of STOP: done=1 and busy=0 in the same cycle, then return to IDLE.
REQ-026 Latency: busy high for exactly 80*D cycles on a full transaction and 44*D cycles on an address NACK.
REQ-027 start while busy is ignored; input changes after acceptance have no effect.
REQ-028 start asserted in the done cycle is not accepted; the earliest accept is the following cycle.
REQ-029 clk_div changes take effect only at the next accepted start (dynamic baud per transaction).

Reset
REQ-030 rst=1: state=IDLE, scl=1, sda released, busy=0, done=0, ack_err=0, rdata=0, counters=0, all effective at the next edge.
REQ-031 rst during a transaction aborts it immediately with no STOP generated and no done pulse.

Verification
REQ-032 Write, addr=7'h57, wdata=8'hA5, clk_div=4, ACKing slave: bus shows START, 0xAE, ACK, 0xA5, ACK, STOP; done after 320 cycles; ack_err=0.
REQ-033 Read, addr=7'h57, slave returns 8'hCD, clk_div=2: rdata=8'hCD at done; busy width 160 cycles.
REQ-034 Write, addr=7'h20, no slave ACK: ack_err=1; no DATA phase on the bus; busy width 44*D.
REQ-035 Back-to-back transactions, clk_div=3 then clk_div=10: SCL period is 12 clks, then 40 clks; start held high during busy causes no extra transaction.
REQ-036 clk_div=0: SCL period equals 4*DEFAULT_DIV clks.
REQ-037 rst asserted mid-DATA: next edge gives scl=1, sda=z, busy=0, no done; a new transaction then completes normally.
